// File: rtl/mem_pkg.sv
// Data-memory stage package: access size codes, FSM states and
// byte-lane helpers shared by the memory stage and its load aligner.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            size == SZ_BYTE: be = 4'b0001 << off;
            size == SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            size == SZ_WORD: be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            size == SZ_HALF: bad = off[0];
            size == SZ_WORD: bad = |off;
            size == SZ_ILL:  bad = 1'b1;
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load aligner: picks the addressed byte/half/word lane out of a
// memory word, right-justifies it and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        fill_b;
    logic        fill_h;

    assign shifted = word_i >> {off_i, 3'b000};
    assign fill_b  = ~uns_i & shifted[7];
    assign fill_h  = ~uns_i & shifted[15];

    always_comb begin
        data_o = shifted;
        unique case (1'b1)
            size_i == SZ_BYTE: data_o = {{24{fill_b}}, shifted[7:0]};
            size_i == SZ_HALF: data_o = {{16{fill_h}}, shifted[15:0]};
            default:           data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_sized.sv
// Data-memory stage: word RAM with byte/half/word access, programmable
// wait states with a stall back to the pipeline, and alignment errors.
module mem_stage_sized
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       datain,
    output logic [31:0]       dataout,
    output logic              resp_valid,
    output logic              stall,
    output logic              misalign_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

    logic [31:0]      mem_q [DEPTH];
    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [31:0]      dataout_q;
    logic             resp_q;
    logic             err_q;

    logic             in_wait;
    logic             accept;
    logic             bad;
    logic             go;
    logic [IDX_W-1:0] a_idx;
    logic [1:0]       a_off;
    logic [1:0]       a_size;
    logic             a_we;
    logic             a_uns;
    logic [31:0]      a_wdata;
    logic [31:0]      a_wshift;
    logic [3:0]       a_be;
    logic [31:0]      ld_data;
    logic             unused_addr;

    assign in_wait = (state_q == WAIT);
    assign accept  = ~in_wait & req_valid;
    assign bad     = misaligned(req_size, addr[1:0]);
    // No wait states: the access happens on the live request at accept.
    assign go = in_wait ? (cnt_q == 4'd0)
                        : (accept & ~bad & (LATENCY == 0));

    assign a_idx    = in_wait ? idx_q   : addr[IDX_W+1:2];
    assign a_off    = in_wait ? off_q   : addr[1:0];
    assign a_size   = in_wait ? size_q  : req_size;
    assign a_we     = in_wait ? we_q    : req_we;
    assign a_uns    = in_wait ? uns_q   : req_unsigned;
    assign a_wdata  = in_wait ? wdata_q : datain;
    assign a_wshift = a_wdata << {a_off, 3'b000};
    assign a_be     = byte_en(a_size, a_off);

    mem_load_align u_align (
        .word_i (mem_q[a_idx]),
        .off_i  (a_off),
        .size_i (a_size),
        .uns_i  (a_uns),
        .data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (go && a_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) mem_q[a_idx][8*b +: 8] <= a_wshift[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= 32'd0;
            dataout_q <= 32'd0;
            resp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            resp_q <= go;
            err_q  <= accept & bad;
            if (go && !a_we) dataout_q <= ld_data;
            unique case (state_q)
                IDLE: begin
                    if (accept && !bad && LATENCY != 0) begin
                        state_q <= WAIT;
                        cnt_q   <= WAIT_INIT;
                        idx_q   <= addr[IDX_W+1:2];
                        off_q   <= addr[1:0];
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= datain;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= IDLE;
                    else cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dataout      = dataout_q;
    assign resp_valid   = resp_q;
    assign stall        = in_wait;
    assign misalign_err = err_q;
    assign unused_addr  = ^addr[ADDR_W-1:IDX_W+2];

endmodule

// File: tb/tb_mem_stage_sized.sv
// Bench for mem_stage_sized: three instances (0, 3, 5 wait states)
// checked against a byte-addressed memory model, tables and sequences.
module tb_mem_stage_sized;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv   [3];
    logic        we   [3];
    logic [1:0]  sz   [3];
    logic        uns  [3];
    logic [31:0] ad   [3];
    logic [31:0] di   [3];
    logic [31:0] dout [3];
    logic        resp [3];
    logic        stl  [3];
    logic        err  [3];

    logic [7:0]  mb [3][256];
    logic [31:0] exp_dout [3];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_sized #(.DEPTH(64), .ADDR_W(32), .LATENCY(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(we[0]),
        .req_size(sz[0]), .req_unsigned(uns[0]), .addr(ad[0]),
        .datain(di[0]), .dataout(dout[0]), .resp_valid(resp[0]),
        .stall(stl[0]), .misalign_err(err[0]));

    mem_stage_sized #(.DEPTH(64), .ADDR_W(32), .LATENCY(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(we[1]),
        .req_size(sz[1]), .req_unsigned(uns[1]), .addr(ad[1]),
        .datain(di[1]), .dataout(dout[1]), .resp_valid(resp[1]),
        .stall(stl[1]), .misalign_err(err[1]));

    mem_stage_sized #(.DEPTH(64), .ADDR_W(32), .LATENCY(5)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_we(we[2]),
        .req_size(sz[2]), .req_unsigned(uns[2]), .addr(ad[2]),
        .datain(di[2]), .dataout(dout[2]), .resp_valid(resp[2]),
        .stall(stl[2]), .misalign_err(err[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    function automatic int nb(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic legal(input logic [1:0] s, input logic [31:0] a);
        return (s != 2'b11) && ((int'(a[1:0]) % nb(s)) == 0);
    endfunction

    function automatic void mstore(input int d, input logic [31:0] a,
                                   input logic [1:0] s, input logic [31:0] wd);
        for (int k = 0; k < nb(s); k++)
            mb[d][(int'(a[7:0]) + k) % 256] = wd[8*k +: 8];
    endfunction

    function automatic logic [31:0] mload(input int d, input logic [31:0] a,
                                          input logic [1:0] s, input logic u);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nb(s);
        for (int k = 0; k < n; k++)
            v[8*k +: 8] = mb[d][(int'(a[7:0]) + k) % 256];
        if (n < 4 && !u && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] xp);
        n_tests++;
        if (act !== xp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h",
                     nm, d, $time, act, xp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the last response cycle.
    task automatic access(input int d, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] wd);
        logic ok;
        int lat;
        int n;
        lat = lat_of(d);
        ok  = legal(s, a);
        rv[d] = 1'b1; we[d] = w; sz[d] = s; uns[d] = u; ad[d] = a; di[d] = wd;
        @(posedge clk);
        #1 rv[d] = 1'b0;
        if (ok) begin
            if (w) mstore(d, a, s, wd);
            else exp_dout[d] = mload(d, a, s, u);
        end
        n = ok ? lat + 1 : 1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk("resp_valid", d, 32'(resp[d]), 32'(ok && c == n));
            chk("stall", d, 32'(stl[d]), 32'(ok && c <= lat));
            chk("misalign_err", d, 32'(err[d]), 32'(!ok));
        end
        chk("dataout", d, dout[d], exp_dout[d]);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] xp;
    } vec_t;

    vec_t tbl [20];

    initial begin
        int resps;
        int stalls;
        logic [31:0] ra;
        logic [1:0]  rs;

        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'b00; uns[d] = 1'b0;
            ad[d] = 32'd0; di[d] = 32'd0; exp_dout[d] = 32'd0;
            for (int i = 0; i < 256; i++) mb[d][i] = 8'h00;
        end

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h04,  32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h08,  32'h0,        32'hDEADBEEF};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h09,  32'h80,       32'hDEADBEEF};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h09,  32'h0,        32'hFFFFFF80};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 32'h09,  32'h0,        32'h00000080};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h08,  32'h0,        32'h00008000};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h0E,  32'h1234,     32'h00008000};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h0E,  32'h0,        32'h00001234};
        tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h0F,  32'h0,        32'h00001234};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h55,       32'h00001234};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h00,  32'h0,        32'h00000055};
        tbl[12] = '{1'b0, 2'b11, 1'b0, 32'h00,  32'h0,        32'h00000055};
        tbl[13] = '{1'b1, 2'b01, 1'b0, 32'h0A,  32'h9ABC,     32'h00000055};
        tbl[14] = '{1'b0, 2'b01, 1'b0, 32'h0A,  32'h0,        32'hFFFF9ABC};
        tbl[15] = '{1'b0, 2'b01, 1'b1, 32'h0A,  32'h0,        32'h00009ABC};
        tbl[16] = '{1'b1, 2'b10, 1'b0, 32'h11,  32'hFFFFFFFF, 32'h00009ABC};
        tbl[17] = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h00000000};
        tbl[18] = '{1'b0, 2'b00, 1'b0, 32'h0B,  32'h0,        32'hFFFFFF9A};
        tbl[19] = '{1'b0, 2'b10, 1'b0, 32'h08,  32'h0,        32'h9ABC8000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset dataout", d, dout[d], 32'd0);
            chk("reset resp_valid", d, 32'(resp[d]), 32'd0);
            chk("reset stall", d, 32'(stl[d]), 32'd0);
            chk("reset misalign_err", d, 32'(err[d]), 32'd0);
        end
        rst = 1'b0;

        // Give every RAM a known all-zero image through the store path.
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 64; w++)
                access(d, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'd0);

        for (int i = 0; i < 20; i++) begin
            access(0, tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].wd);
            chk("table dataout", 0, dout[0], tbl[i].xp);
        end

        // Three wait states, with a stray request while stalled.
        access(1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h12345678);
        rv[1] = 1'b1; we[1] = 1'b0; sz[1] = 2'b10; ad[1] = 32'h04;
        @(posedge clk);
        #1 rv[1] = 1'b0;
        resps = 0;
        stalls = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("lat3 resp_valid", 1, 32'(resp[1]), 32'(c == 4));
            chk("lat3 stall", 1, 32'(stl[1]), 32'(c <= 3));
            resps += int'(resp[1]);
            stalls += int'(stl[1]);
            if (c == 1) begin
                rv[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10;
                ad[1] = 32'h04; di[1] = 32'hFFFFFFFF;
            end
            if (c == 2) rv[1] = 1'b0;
        end
        chk("lat3 resp count", 1, 32'(resps), 32'd1);
        chk("lat3 stall count", 1, 32'(stalls), 32'd3);
        exp_dout[1] = 32'h12345678;
        chk("lat3 dataout", 1, dout[1], exp_dout[1]);
        access(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);

        // Five wait states, reset two cycles after a store is accepted.
        rv[2] = 1'b1; we[2] = 1'b1; sz[2] = 2'b10;
        ad[2] = 32'h10; di[2] = 32'hAAAAAAAA;
        @(posedge clk);
        #1 rv[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lat5 stall before rst", 2, 32'(stl[2]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst stall", 2, 32'(stl[2]), 32'd0);
        chk("rst resp_valid", 2, 32'(resp[2]), 32'd0);
        chk("rst misalign_err", 2, 32'(err[2]), 32'd0);
        chk("rst dataout", 0, dout[0], 32'd0);
        for (int d = 0; d < 3; d++) exp_dout[d] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post-rst resp_valid", 2, 32'(resp[2]), 32'd0);
        end
        access(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("discarded store", 2, dout[2], 32'h00000000);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 150; i++) begin
                rs = ($urandom_range(0, 9) == 0) ? 2'b11
                                                 : 2'($urandom_range(0, 2));
                ra = $urandom;
                if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nb(rs) - 1);
                access(d, 1'($urandom_range(0, 1)), rs,
                       1'($urandom_range(0, 1)), ra, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
Parametrised successor to the pipeline's data-memory stage: a synchronous word-organised RAM with byte, halfword and word loads/stores, plus sign or zero extension on loads. A programmable wait-state count models slow memory and drives a stall flag back to the pipeline, and misaligned or illegal accesses are reported. Sits between EXE and WB; addressing is byte-based (word index = addr >> 2).

Parameters:
DEPTH, 64, number of 32-bit words; power of 2, minimum 4
ADDR_W, 32, byte-address width
LATENCY, 0, wait states per access, 0..15

Ports:
clk  in  1  clock, all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  access request, sampled only when not busy
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
addr  in  ADDR_W  byte address
datain  in  32  store data; the low byte/half/word is used
dataout  out  32  load result, registered
resp_valid  out  1  one-cycle pulse when an access completes
stall  out  1  high while an accepted access is waiting
misalign_err  out  1  one-cycle pulse for a rejected access

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE; dataout=0, resp_valid=0, stall=0, misalign_err=0, counter=0.
  - A pending access is discarded; a pending store is never written.
  - RAM contents are not altered by reset; simulation initialises the RAM to all zero.
- Index: word = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Accept: in IDLE, at a rising edge with req_valid=1. addr, datain, size, we and unsigned are captured.
- Alignment check at accept:
  - half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always illegal.
  - On violation: no RAM access, FSM stays IDLE, misalign_err=1 in the next cycle only, resp_valid=0, dataout unchanged.
- FSM states IDLE and WAIT, with a 4-bit counter:
  - LATENCY=0: the access is performed at the accept edge; resp_valid=1 in the next cycle; FSM stays IDLE.
  - LATENCY=N>0: accept moves to WAIT with counter=N-1. Each edge in WAIT decrements the counter.
  - At the edge where the counter is 0 in WAIT, the access is performed, resp_valid is set for the next cycle, and the FSM returns to IDLE.
  - Net: resp_valid is high exactly N+1 cycles after the accept edge.
- stall = (state==WAIT), combinational from the state register. req_valid is ignored while stall=1.
- Back-to-back requests: a new request may be accepted in the same cycle resp_valid is high. The requester must drop req_valid after accept or it is treated as a new request.
- Store:
  - byte: datain[7:0] goes to lane addr[1:0].
  - half: datain[15:0] goes to lanes {addr[1],0}+1:{addr[1],0}.
  - word: all 4 lanes.
  - Other lanes are preserved. dataout is not updated by a store.
- Load:
  - Select the lane(s) by addr[1:0] and right-justify them.
  - Extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
  - dataout updates only on load completion.
- Timing is the same for loads and stores; resp_valid pulses for both.

Decomposition:
- Package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL), state enum (IDLE, WAIT), byte-enable generation function.
- Sub-module mem_load_align: combinational lane select plus sign/zero extension (inputs word, addr[1:0], size, unsigned; output 32-bit). Reused later by any cache load path.

Test Plan:
- LATENCY=0, store word 0xDEADBEEF at 0x04, then load word at 0x04 -> resp_valid the cycle after each accept; dataout=0xDEADBEEF; stall never high.
- Store byte 0x80 at 0x09 over word 0 at index 2; load byte signed at 0x09 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; word load at 0x08 -> 0x00008000.
- Store half 0x1234 at 0x0E; load half signed at 0x0E -> 0x00001234; half load at 0x0F -> misalign_err pulse, no resp_valid, dataout unchanged.
- LATENCY=3, load at 0x04 -> stall high for exactly 3 cycles; resp_valid 4 cycles after accept; a req_valid pulse during stall is ignored (no extra resp).
- DEPTH=64, store word 0x55 at 0x100 -> readable at 0x000 (wrap); req_size=11 -> misalign_err pulse.
- LATENCY=5, store 0xAAAA_AAAA at 0x10; assert rst 2 cycles after accept -> all outputs 0 immediately; later load at 0x10 returns the old value 0x00000000.
